baud_tick_gen: RTL and testbench
================================

BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the divisor width in bits (range 2..32).
REQ-002 The block SHALL have parameter OSR, default 16, giving oversample ticks per bit (power of two, 4..256); OSR_W = log2(OSR).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  count enable; counters hold when low.
REQ-006 restart  input  1  synchronous phase realign; clears phase and reloads the prescaler.
REQ-007 divisor  input  WIDTH  prescaler terminal value; os_tick period is divisor+1 clk cycles.
REQ-008 frac  input  4  fractional period extension in 1/16 clk units; used only when BAUD_TICK_GEN_FRAC_EN is defined.
REQ-009 os_tick  output  1  registered one-cycle oversample tick.
REQ-010 half_tick  output  1  registered one-cycle pulse on the OSR/2-th os_tick of each bit (mid-bit sample point).
REQ-011 bit_tick  output  1  registered one-cycle pulse on the OSR-th os_tick of each bit.
REQ-012 os_count  output  OSR_W  current oversample phase, 0..OSR-1.

Function
REQ-013 The prescaler SHALL be a WIDTH+1-bit down-counter cnt, so that divisor+1 never overflows.
REQ-014 On an edge with enable=1, restart=0 and cnt!=0, cnt SHALL decrement by 1 and all tick outputs SHALL be 0 next cycle.
REQ-015 On an edge with enable=1, restart=0 and cnt==0 (a tick event):
- os_tick SHALL be 1 next cycle.
- cnt SHALL reload with divisor (sampled at this edge), plus 1 if the fractional carry of REQ-026 is set.
- os_count SHALL increment, wrapping from OSR-1 to 0.
REQ-016 On a tick event with os_count==OSR/2-1, half_tick SHALL be 1 next cycle.
REQ-017 On a tick event with os_count==OSR-1, bit_tick SHALL be 1 next cycle.
REQ-018 Changes on divisor SHALL take effect only at the next reload (tick event or restart); a period in progress SHALL NOT be altered.
REQ-019 With divisor=0 and no fractional carry, os_tick SHALL be 1 on every cycle while enable=1.
REQ-020 restart=1 SHALL take priority over enable: cnt<=divisor, os_count<=0, fractional accumulator<=0, all tick outputs 0 next cycle.
REQ-021 If restart is sampled at edge t and enable is held high, the first os_tick SHALL be visible after edge t+divisor+1.
REQ-022 With enable=0 and restart=0, cnt, os_count and the accumulator SHALL hold, and all tick outputs SHALL be 0 next cycle.
REQ-023 Tick outputs SHALL never be high for more than one consecutive cycle, except os_tick when divisor=0 (REQ-019).

Reset
REQ-024 While reset_n=0: cnt=0, os_count=0, accumulator=0, os_tick=0, half_tick=0, bit_tick=0, regardless of clk.
REQ-025 After reset_n deasserts, the first edge with enable=1 SHALL be a tick event (cnt==0), so os_tick asserts one cycle after enable rises; a mid-operation reset SHALL discard all phase.

Configuration
REQ-026 When BAUD_TICK_GEN_FRAC_EN is defined:
- A 4-bit accumulator SHALL add frac on every tick event.
- A carry out of bit 3 SHALL extend the next prescaler period by 1 cycle.
- Average os_tick period SHALL be divisor+1+frac/16 cycles.
REQ-027 When BAUD_TICK_GEN_FRAC_EN is undefined, the accumulator SHALL be absent, frac SHALL be ignored, and the period SHALL be exactly divisor+1.

Verification
REQ-028 Scenario: WIDTH=16, OSR=16, divisor=9, restart pulse, then enable held -> os_tick every 10 cycles, half_tick on the 8th os_tick, bit_tick on the 16th, bit_tick period 160 cycles.
REQ-029 Scenario: divisor=0 -> os_tick high continuously; bit_tick every 16 cycles; os_count cycles 0..15.
REQ-030 Scenario: divisor changed 9->4 mid-period -> the current period completes at 10 cycles, the next is 5.
REQ-031 Scenario: enable dropped for 7 cycles mid-period -> os_count and cnt frozen; the resumed period totals 10 enabled cycles; no ticks while low.
REQ-032 Scenario: FRAC_EN build, divisor=9, frac=8 -> os_tick periods alternate 10 and 11 cycles (average 10.5); non-FRAC build with same inputs -> constant 10.
REQ-033 Scenario: reset_n asserted mid-bit -> all outputs 0 immediately; after release with enable=1, os_tick asserts 1 cycle later and os_count restarts from 0.

Source files
------------

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - Prescaled oversample/half-bit/bit tick generator.
// Optional fractional period extension is enabled by defining BAUD_TICK_GEN_FRAC_EN.
module baud_tick_gen #(
    parameter int WIDTH = 16,
    parameter int OSR   = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    restart,
    input  logic [WIDTH-1:0]        divisor,
    input  logic [3:0]              frac,
    output logic                    os_tick,
    output logic                    half_tick,
    output logic                    bit_tick,
    output logic [$clog2(OSR)-1:0]  os_count
);

    localparam int OSR_W = $clog2(OSR);
    localparam logic [OSR_W-1:0] HALF_LAST = OSR_W'(OSR / 2 - 1);
    localparam logic [OSR_W-1:0] BIT_LAST  = OSR_W'(OSR - 1);

    // One extra bit so divisor+carry can never wrap.
    logic [WIDTH:0] cnt;
    logic [WIDTH:0] reload;
    logic           carry;

`ifdef BAUD_TICK_GEN_FRAC_EN
    logic [3:0] acc;
    logic [3:0] acc_sum;

    assign {carry, acc_sum} = {1'b0, acc} + {1'b0, frac};
`else
    logic unused_frac;

    assign carry       = 1'b0;
    assign unused_frac = ^frac;
`endif

    assign reload = {1'b0, divisor} + {{WIDTH{1'b0}}, carry};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            os_count  <= '0;
            os_tick   <= 1'b0;
            half_tick <= 1'b0;
            bit_tick  <= 1'b0;
`ifdef BAUD_TICK_GEN_FRAC_EN
            acc       <= '0;
`endif
        end else if (restart) begin
            cnt       <= {1'b0, divisor};
            os_count  <= '0;
            os_tick   <= 1'b0;
            half_tick <= 1'b0;
            bit_tick  <= 1'b0;
`ifdef BAUD_TICK_GEN_FRAC_EN
            acc       <= '0;
`endif
        end else if (enable && cnt == '0) begin
            // Tick event: reload samples divisor here, so mid-period changes wait.
            cnt       <= reload;
            os_count  <= os_count + 1'b1;
            os_tick   <= 1'b1;
            half_tick <= (os_count == HALF_LAST);
            bit_tick  <= (os_count == BIT_LAST);
`ifdef BAUD_TICK_GEN_FRAC_EN
            acc       <= acc_sum;
`endif
        end else begin
            if (enable) begin
                cnt <= cnt - 1'b1;
            end
            os_tick   <= 1'b0;
            half_tick <= 1'b0;
            bit_tick  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_baud_tick_gen.sv
// tb/tb_baud_tick_gen.sv - Directed self-checking bench for baud_tick_gen.
module tb_baud_tick_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        restart;
    logic [15:0] divisor;
    logic [3:0]  frac;
    logic        os_tick;
    logic        half_tick;
    logic        bit_tick;
    logic [3:0]  os_count;

    int checks = 0;
    int passed = 0;
    int stray  = 0;

    baud_tick_gen #(.WIDTH(16), .OSR(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .restart   (restart),
        .divisor   (divisor),
        .frac      (frac),
        .os_tick   (os_tick),
        .half_tick (half_tick),
        .bit_tick  (bit_tick),
        .os_count  (os_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycles until os_tick is seen, bounded; also tallies half/bit pulses without os_tick.
    task automatic wait_tick(output int n);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            n++;
            if (!os_tick && (half_tick || bit_tick)) stray++;
            if (os_tick) break;
        end
        if (!os_tick) check("wait_tick_timeout", 0, 1);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    int n;
    int cnt_os;
    int cnt_bit;
    logic [3:0] frozen;
    int frac_exp [5];

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        restart = 1'b0;
        divisor = 16'd9;
        frac    = 4'd0;
        #23;
        check("rst_os_tick", os_tick, 0);
        check("rst_half_tick", half_tick, 0);
        check("rst_bit_tick", bit_tick, 0);
        check("rst_os_count", os_count, 0);

        reset_n = 1'b1;
        step();
        check("idle_no_tick", os_tick, 0);
        enable = 1'b1;
        step();
        check("first_tick_after_enable", os_tick, 1);
        check("first_tick_os_count", os_count, 1);

        // Divisor 9: period 10, half on 8th tick, bit on 16th.
        pulse_restart();
        check("restart_os_tick", os_tick, 0);
        check("restart_os_count", os_count, 0);
        for (int k = 1; k <= 16; k++) begin
            wait_tick(n);
            check($sformatf("period_%0d", k), n, 10);
            check($sformatf("half_%0d", k), half_tick, (k == 8) ? 1 : 0);
            check($sformatf("bit_%0d", k), bit_tick, (k == 16) ? 1 : 0);
            check($sformatf("os_count_%0d", k), os_count, k % 16);
        end
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            n++;
            if (bit_tick) break;
        end
        check("bit_period", n, 160);
        check("stray_pulses", stray, 0);

        // Divisor 0: os_tick every cycle.
        divisor = 16'd0;
        pulse_restart();
        cnt_os  = 0;
        cnt_bit = 0;
        for (int k = 1; k <= 32; k++) begin
            step();
            if (os_tick) cnt_os++;
            if (bit_tick) cnt_bit++;
            if (k == 5) check("div0_os_count_5", os_count, 5);
            if (k == 16) check("div0_bit_at_16", bit_tick, 1);
        end
        check("div0_os_ticks", cnt_os, 32);
        check("div0_bit_ticks", cnt_bit, 2);
        check("div0_os_count_wrap", os_count, 0);

        // Divisor change mid-period takes effect at next reload.
        divisor = 16'd9;
        pulse_restart();
        for (int k = 0; k < 3; k++) step();
        divisor = 16'd4;
        wait_tick(n);
        check("divchg_current", n + 3, 10);
        wait_tick(n);
        check("divchg_next", n, 5);

        // Enable low freezes state and suppresses ticks.
        divisor = 16'd9;
        pulse_restart();
        for (int k = 0; k < 4; k++) step();
        frozen = os_count;
        enable = 1'b0;
        cnt_os = 0;
        for (int k = 0; k < 7; k++) begin
            step();
            if (os_tick || half_tick || bit_tick) cnt_os++;
        end
        check("hold_no_ticks", cnt_os, 0);
        check("hold_os_count", os_count, frozen);
        enable = 1'b1;
        wait_tick(n);
        check("hold_resume_period", n, 6);

        // Fractional extension.
`ifdef BAUD_TICK_GEN_FRAC_EN
        frac_exp = '{10, 10, 11, 10, 11};
`else
        frac_exp = '{10, 10, 10, 10, 10};
`endif
        frac = 4'd8;
        pulse_restart();
        for (int k = 0; k < 5; k++) begin
            wait_tick(n);
            check($sformatf("frac_period_%0d", k), n, frac_exp[k]);
        end
        frac = 4'd0;

        // Mid-bit asynchronous reset.
        wait_tick(n);
        for (int k = 0; k < 3; k++) step();
        wait_tick(n);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_os_tick", os_tick, 0);
        check("midrst_os_count", os_count, 0);
        #2;
        reset_n = 1'b1;
        step();
        check("postrst_tick", os_tick, 1);
        check("postrst_os_count", os_count, 1);
        wait_tick(n);
        check("postrst_period", n, 10);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
